fb_vga_scanout: RTL and testbench
=================================

// Module: fb_vga_scanout
// PURPOSE
//   Read side of the 320x240 RGB565 frame buffer. Generates 640x480@60 VGA timing from the
//   system clock via a pixel-tick divider. Drives frame-buffer read addresses with 2x2 pixel
//   doubling, absorbs the buffer's 1-clk read latency, and outputs aligned 4:4:4 RGB and syncs.
//   Sits between the frame buffer read port and the board VGA pins.
// PARAMETERS
//   CLK_DIV   4    clk cycles per pixel tick (100 MHz -> 25 MHz); must be >= 3
//   H_ACTIVE  640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48 (total 800)
//   V_ACTIVE  480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33 (total 525)
//   FB_W      320  frame buffer width (pixels);  FB_H 240 frame buffer height (lines)
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   rst_n      in   1   synchronous reset, active-low
//   read_addr  out  17  frame buffer read address, row-major: y*FB_W + x
//   fb_pixel   in   16  frame buffer read data, RGB565, valid 1 clk after read_addr
//   hsync      out  1   horizontal sync, active-low
//   vsync      out  1   vertical sync, active-low
//   vga_r      out  4   red   = fb_pixel[15:12] in active area, else 0
//   vga_g      out  4   green = fb_pixel[10:7]  in active area, else 0
//   vga_b      out  4   blue  = fb_pixel[4:1]   in active area, else 0
//   video_on   out  1   high while vga_r/g/b carry an active-area pixel
//   frame_end  out  1   1-clk pulse when the last pixel (h=799,v=524) is emitted; buffer-swap hint
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): div_cnt=0, h_cnt=0, v_cnt=0, read_addr=0, hsync=1, vsync=1,
//     vga_r/g/b=0, video_on=0, frame_end=0. Mid-frame reset aborts the frame; no partial state kept.
//   Tick: tick=1 when div_cnt==CLK_DIV-1; div_cnt wraps to 0 there, else increments.
//     The first tick occurs on the CLK_DIV-th posedge after rst_n rises.
//   Counters (update on tick only): h_cnt 0..799 wraps to 0. On that wrap v_cnt increments,
//     0..524 wrapping to 0. Widths: h_cnt 10 b, v_cnt 10 b.
//   active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//   read_addr: registered every clk = active ? (v_cnt>>1)*FB_W + (h_cnt>>1) : 0.
//     Multiply by 320 is implemented as (y<<8)+(y<<6), 17-bit; max 76799, never exceeds.
//   Latency: counters change at a tick; read_addr follows 1 clk later; fb_pixel follows 1 clk
//     after that. With CLK_DIV>=3, fb_pixel is valid before the next tick.
//   Output registers (update on tick only) sample the current h_cnt/v_cnt and fb_pixel:
//     hsync    = ~(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1])  i.e. low for h 656..751
//     vsync    = ~(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1])  i.e. low for v 490..491
//     video_on = active; RGB fields from fb_pixel if active, else 0.
//   All outputs lag counters by exactly one tick, so syncs, RGB and video_on remain aligned.
//   frame_end: 1 for the single clk of the tick where the outputs take the pixel for
//     (h=799, v=524); 0 otherwise.
//   No handshake: read port is always enabled. Writes to the buffer may be concurrent;
//     tearing is the writer's concern (use frame_end).
// TESTING
//   1 Hold rst_n=0 5 clks, release -> outputs equal reset values until the first tick at
//     clk 4; then hsync/vsync=1, video_on=1.
//   2 Free run 1 frame with CLK_DIV=4 -> hsync period 3200 clks with low width 384 clks;
//     vsync period 1,680,000 clks with low width 6400 clks.
//   3 Model buffer with mem[a]=a[15:0] -> screen (x=2k, 2k+1, row 2j, 2j+1) shows
//     fb_pixel=j*320+k; read_addr peaks at 76799.
//   4 Model buffer returning 16'hFFFF everywhere -> RGB=4'hF only while video_on; RGB=0 in
//     blanking (h 640..799 and v 480..524).
//   5 Run to end of frame -> frame_end is exactly one 1-clk pulse per frame, 1,680,000 clks apart.
//   6 Assert rst_n=0 for 1 clk at h=300, v=200 -> next tick restarts at (0,0); read_addr=0
//     and all outputs at reset values meanwhile.

Source files
------------

// File: rtl/fb_vga_scanout.sv
// fb_vga_scanout: read side of a 320x240 RGB565 frame buffer. It generates
// 640x480@60 VGA timing from the system clock using a pixel-tick divider, and
// reads the buffer with 2x2 pixel doubling. It absorbs the buffer's 1-clk read
// latency and drives aligned 4:4:4 RGB, syncs, video_on and a frame_end pulse.
// The timing geometry is parameterised. The defaults give 640x480@60.
module fb_vga_scanout #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] read_addr,
  input  logic [15:0] fb_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        video_on,
  output logic        frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The read pipeline needs the pixel back before the next tick.
  // The address space is 17 bits.
  if (CLK_DIV < 3) begin : g_bad_div
    $error("fb_vga_scanout: CLK_DIV must be >= 3");
  end
  if (FB_W * FB_H > 131072) begin : g_bad_fb
    $error("fb_vga_scanout: frame buffer exceeds 17-bit address space");
  end

  // Row base address y*FB_W. For the 320-wide buffer this is (y<<8)+(y<<6).
  function automatic logic [16:0] row_base(input logic [9:0] y);
    logic [16:0] y17;
    y17 = {7'd0, y};
    if (FB_W == 320) return (y17 << 8) + (y17 << 6);
    else             return 17'(y17 * 17'(FB_W));
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [16:0]      addr_q, addr_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             video_on_q, video_on_d, frame_end_q, frame_end_d;
  logic             tick, active;

  // Only some RGB565 bits feed the 4:4:4 outputs.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{fb_pixel[11], fb_pixel[6:5], fb_pixel[0]};

  // Pixel tick divider and raster counters; counters advance on tick only.
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Read address follows the counters one clk later and is zero in blanking.
  always_comb begin
    active = (h_q < H_ACT) && (v_q < V_ACT);
    addr_d = active ? row_base(v_q >> 1) + {8'd0, h_q[9:1]} : 17'd0;
  end

  // Output stage: on tick, take the current position and the returned pixel.
  always_comb begin
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    video_on_d  = video_on_q;
    frame_end_d = 1'b0;
    if (tick) begin
      hsync_d     = ~((h_q >= HS_FIRST) && (h_q <= HS_LAST));
      vsync_d     = ~((v_q >= VS_FIRST) && (v_q <= VS_LAST));
      video_on_d  = active;
      r_d         = active ? fb_pixel[15:12] : 4'd0;
      g_d         = active ? fb_pixel[10:7]  : 4'd0;
      b_d         = active ? fb_pixel[4:1]   : 4'd0;
      frame_end_d = (h_q == H_LAST) && (v_q == V_LAST);
    end
  end

  // State registers with synchronous active-low reset; reset aborts the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      addr_q      <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      video_on_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      addr_q      <= addr_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      video_on_q  <= video_on_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign read_addr = addr_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign video_on  = video_on_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// Bench for fb_vga_scanout. A reduced-geometry instance covers whole frames
// cheaply. A default-geometry instance checks 320-wide addressing and real
// line timing over the first lines. The reference model maps a clock count
// since reset to the expected raster position and outputs.
module tb_fb_vga_scanout;

  localparam int D = 4;
  // reduced geometry
  localparam int S_HA = 20, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_FBW = 10, S_FBH = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME = S_HT * S_VT * D;

  typedef struct packed {
    logic [16:0] addr;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        von;
    logic        fe;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance signals
  logic [16:0] s_addr;
  logic [15:0] s_pix;
  logic        s_hsync, s_vsync, s_von, s_fe;
  logic [3:0]  s_r, s_g, s_b;
  // full instance signals
  logic [16:0] f_addr;
  logic [15:0] f_pix;
  logic        f_hsync, f_vsync, f_von, f_fe;
  logic [3:0]  f_r, f_g, f_b;

  fb_vga_scanout #(
    .CLK_DIV(D), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .FB_W(S_FBW), .FB_H(S_FBH)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .read_addr(s_addr), .fb_pixel(s_pix),
    .hsync(s_hsync), .vsync(s_vsync), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .video_on(s_von), .frame_end(s_fe)
  );

  fb_vga_scanout dut_full (
    .clk(clk), .rst_n(rst_n), .read_addr(f_addr), .fb_pixel(f_pix),
    .hsync(f_hsync), .vsync(f_vsync), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .video_on(f_von), .frame_end(f_fe)
  );

  obs_t s_obs, f_obs, rst_v;
  assign s_obs = {s_addr, s_hsync, s_vsync, s_r, s_g, s_b, s_von, s_fe};
  assign f_obs = {f_addr, f_hsync, f_vsync, f_r, f_g, f_b, f_von, f_fe};

  // frame buffer models with 1-clk read latency
  logic [15:0] s_mem [0:S_FBW*S_FBH-1];
  int s_mode = 0; // 0 random table, 1 ramp, 2 all ones
  always @(posedge clk) begin
    if (s_mode == 1)      s_pix <= s_addr[15:0];
    else if (s_mode == 2) s_pix <= 16'hFFFF;
    else if (int'(s_addr) < S_FBW * S_FBH) s_pix <= s_mem[int'(s_addr)];
    else                  s_pix <= 16'hDEAD;
  end
  always @(posedge clk) f_pix <= f_addr[15:0];

  // clock edges since reset release
  int edge_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // Expected outputs after clock edge e: tick n = e/D has shown raster
  // position n-1; read_addr reflects the position held one clk earlier.
  function automatic obs_t model(input int e, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va,
                                 input int vfp, input int vsw, input int vbp,
                                 input int fbw, input int mode);
    obs_t o;
    int ht, vt, tot, n, p, h, v, a;
    logic [15:0] px;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    tot = ht * vt;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (e >= 1) begin
      n = ((e - 1) / D) % tot;
      h = n % ht;
      v = n / ht;
      if (h < ha && v < va) o.addr = 17'((v / 2) * fbw + h / 2);
    end
    n = e / D;
    if (n >= 1) begin
      p = (n - 1) % tot;
      h = p % ht;
      v = p / ht;
      o.hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
      o.vs  = !(v >= va + vfp && v < va + vfp + vsw);
      o.von = (h < ha) && (v < va);
      if (o.von) begin
        a = (v / 2) * fbw + h / 2;
        if (mode == 1)      px = 16'(a);
        else if (mode == 2) px = 16'hFFFF;
        else                px = s_mem[a];
        o.r = px[15:12];
        o.g = px[10:7];
        o.b = px[4:1];
      end
      o.fe = (e % D == 0) && (p == tot - 1);
    end
    return o;
  endfunction

  function automatic obs_t model_small(input int e);
    return model(e, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_FBW, s_mode);
  endfunction

  task automatic fill_random_mem();
    for (int i = 0; i < S_FBW * S_FBH; i++) s_mem[i] = 16'($urandom);
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    s_mode = 0;
    fill_random_mem();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (s_obs !== rst_v) begin
        errors++;
        $display("FAIL reset_hold got %h exp %h", s_obs, rst_v);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== rst_v) begin
        errors++;
        $display("FAIL pre_tick e=%0d got %h exp %h", e, s_obs, rst_v);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_hsync, s_vsync, s_von} !== 3'b111) begin
      errors++;
      $display("FAIL first_tick_small got %b exp 111", {s_hsync, s_vsync, s_von});
    end
    checks++;
    if ({f_hsync, f_vsync, f_von} !== 3'b111) begin
      errors++;
      $display("FAIL first_tick_full got %b exp 111", {f_hsync, f_vsync, f_von});
    end
  endtask

  task automatic test_random_frame();
    obs_t exp_o;
    logic [16:0] max_addr;
    max_addr = '0;
    repeat (S_FRAME + 100) begin
      @(negedge clk);
      exp_o = model_small(edge_cnt);
      if (s_addr > max_addr) max_addr = s_addr;
      checks++;
      if (s_obs !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL random_frame e=%0d got %h exp %h", edge_cnt, s_obs, exp_o);
      end
    end
    checks++;
    if (max_addr !== 17'((S_VA / 2 - 1) * S_FBW + S_HA / 2 - 1)) begin
      errors++;
      $display("FAIL addr_peak got %0d exp %0d", max_addr, (S_VA / 2 - 1) * S_FBW + S_HA / 2 - 1);
    end
  endtask

  task automatic test_white();
    obs_t exp_o;
    s_mode = 2;
    hold_reset(3);
    repeat (S_FRAME + 50) begin
      @(negedge clk);
      exp_o = model_small(edge_cnt);
      checks++;
      if (s_obs !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL white_frame e=%0d got %h exp %h", edge_cnt, s_obs, exp_o);
      end
      checks++;
      if ({s_r, s_g, s_b} !== (s_von ? 12'hFFF : 12'h000)) begin
        errors++;
        if (errors < 20) $display("FAIL white_rgb e=%0d got %h von %b", edge_cnt, {s_r, s_g, s_b}, s_von);
      end
    end
  endtask

  task automatic test_sync_frame_end();
    int fe_n, fe_t0, fe_t1;
    int hs_fall0, hs_fall1, hs_rise0, vs_fall0, vs_fall1, vs_rise0;
    logic hs_prev, vs_prev;
    s_mode = 0;
    fill_random_mem();
    hold_reset(2);
    fe_n = 0; fe_t0 = -1; fe_t1 = -1;
    hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1;
    vs_fall0 = -1; vs_fall1 = -1; vs_rise0 = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
    repeat (2 * S_FRAME + 200) begin
      @(negedge clk);
      if (s_fe === 1'b1) begin
        if (fe_n == 0) fe_t0 = edge_cnt;
        if (fe_n == 1) fe_t1 = edge_cnt;
        fe_n++;
      end
      if (hs_prev && !s_hsync) begin
        if (hs_fall0 < 0) hs_fall0 = edge_cnt;
        else if (hs_fall1 < 0) hs_fall1 = edge_cnt;
      end
      if (!hs_prev && s_hsync && hs_rise0 < 0) hs_rise0 = edge_cnt;
      if (vs_prev && !s_vsync) begin
        if (vs_fall0 < 0) vs_fall0 = edge_cnt;
        else if (vs_fall1 < 0) vs_fall1 = edge_cnt;
      end
      if (!vs_prev && s_vsync && vs_rise0 < 0) vs_rise0 = edge_cnt;
      hs_prev = s_hsync;
      vs_prev = s_vsync;
    end
    checks++;
    if (fe_n != 2) begin
      errors++;
      $display("FAIL frame_end_count got %0d exp 2", fe_n);
    end
    checks++;
    if (fe_t0 != S_FRAME) begin
      errors++;
      $display("FAIL frame_end_first got %0d exp %0d", fe_t0, S_FRAME);
    end
    checks++;
    if (fe_t1 - fe_t0 != S_FRAME) begin
      errors++;
      $display("FAIL frame_end_spacing got %0d exp %0d", fe_t1 - fe_t0, S_FRAME);
    end
    checks++;
    if (hs_fall1 - hs_fall0 != S_HT * D) begin
      errors++;
      $display("FAIL hsync_period got %0d exp %0d", hs_fall1 - hs_fall0, S_HT * D);
    end
    checks++;
    if (hs_rise0 - hs_fall0 != S_HS * D) begin
      errors++;
      $display("FAIL hsync_width got %0d exp %0d", hs_rise0 - hs_fall0, S_HS * D);
    end
    checks++;
    if (vs_fall1 - vs_fall0 != S_FRAME) begin
      errors++;
      $display("FAIL vsync_period got %0d exp %0d", vs_fall1 - vs_fall0, S_FRAME);
    end
    checks++;
    if (vs_rise0 - vs_fall0 != S_VS * S_HT * D) begin
      errors++;
      $display("FAIL vsync_width got %0d exp %0d", vs_rise0 - vs_fall0, S_VS * S_HT * D);
    end
  endtask

  task automatic test_midframe_reset();
    obs_t exp_o;
    int h, v;
    s_mode = 0;
    fill_random_mem();
    hold_reset(2);
    h = $urandom_range(1, S_HT - 1);
    v = $urandom_range(1, S_VT - 1);
    repeat ((v * S_HT + h) * D + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (s_obs !== rst_v) begin
      errors++;
      $display("FAIL midreset_values h=%0d v=%0d got %h exp %h", h, v, s_obs, rst_v);
    end
    rst_n = 1'b1;
    repeat (400) begin
      @(negedge clk);
      exp_o = model_small(edge_cnt);
      checks++;
      if (s_obs !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL midreset_restart e=%0d got %h exp %h", edge_cnt, s_obs, exp_o);
      end
    end
  endtask

  task automatic test_full_ramp();
    obs_t exp_o;
    int fall0, fall1, rise0;
    logic prev;
    hold_reset(2);
    fall0 = -1; fall1 = -1; rise0 = -1;
    prev = 1'b1;
    repeat (3 * 800 * D + 200) begin
      @(negedge clk);
      exp_o = model(edge_cnt, 640, 16, 96, 48, 480, 10, 2, 33, 320, 1);
      checks++;
      if (f_obs !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL full_ramp e=%0d got %h exp %h", edge_cnt, f_obs, exp_o);
      end
      if (prev && !f_hsync) begin
        if (fall0 < 0) fall0 = edge_cnt;
        else if (fall1 < 0) fall1 = edge_cnt;
      end
      if (!prev && f_hsync && rise0 < 0) rise0 = edge_cnt;
      prev = f_hsync;
    end
    checks++;
    if (fall1 - fall0 != 3200) begin
      errors++;
      $display("FAIL full_hsync_period got %0d exp 3200", fall1 - fall0);
    end
    checks++;
    if (rise0 - fall0 != 384) begin
      errors++;
      $display("FAIL full_hsync_width got %0d exp 384", rise0 - fall0);
    end
  endtask

  initial begin
    rst_v = '0;
    rst_v.hs = 1'b1;
    rst_v.vs = 1'b1;
    test_reset();
    test_random_frame();
    test_white();
    test_sync_frame_end();
    test_midframe_reset();
    test_full_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
